// File: rtl/rt_dbg_sba_obi_bridge.sv
// Bridges the debug module's SBA master port onto one OBI manager port. It allows a
// single outstanding transaction, checks an address window, and times out slow responses.
module rt_dbg_sba_obi_bridge #(
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter logic [AddrWidth-1:0] WinStart      = 32'h0001_0000,
  parameter logic [AddrWidth-1:0] WinEnd        = 32'h0003_FFFF,
  parameter int unsigned          TimeoutCycles = 1024,
  localparam int unsigned         BeWidth       = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sba_req_i,
  input  logic [AddrWidth-1:0] sba_addr_i,
  input  logic                 sba_we_i,
  input  logic [DataWidth-1:0] sba_wdata_i,
  input  logic [BeWidth-1:0]   sba_be_i,
  output logic                 sba_gnt_o,
  output logic                 sba_rvalid_o,
  output logic [DataWidth-1:0] sba_rdata_o,
  output logic                 sba_err_o,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [BeWidth-1:0]   obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
  localparam logic [DataWidth-1:0] TimeoutData = DataWidth'(32'hDEAD_BEEF);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    RSP,
    DRAIN_GNT,
    DRAIN_R
  } state_t;

  state_t               state_q;
  state_t               after_rsp_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeWidth-1:0]   be_q;
  logic                 obi_req_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;

  logic in_window;
  logic cnt_last;

  assign in_window = (sba_addr_i >= WinStart) && (sba_addr_i <= WinEnd) &&
                     (sba_addr_i[1:0] == 2'b00);
  assign cnt_last  = (cnt_q == CntLast);

  // NOTE: sba_gnt_o is the only combinational output; it is gated by rst_ni so every
  // output reads 0 while reset is held, even if the debug module keeps requesting.
  assign sba_gnt_o    = rst_ni && (state_q == IDLE) && sba_req_i;
  assign sba_rvalid_o = rvalid_q;
  assign sba_rdata_o  = rdata_q;
  assign sba_err_o    = err_q;
  assign obi_req_o    = obi_req_q;
  assign obi_addr_o   = addr_q;
  assign obi_we_o     = we_q;
  assign obi_be_o     = be_q;
  assign obi_wdata_o  = wdata_q;
  assign busy_o       = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the payload latches are ordinary flops that drive outputs, so they are
      // reset too; only storage arrays would be left unreset.
      state_q     <= IDLE;
      after_rsp_q <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      obi_req_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first, case branches override later in the block;
      // the last scheduled assignment wins, so rvalid_q is a single-cycle pulse.
      rvalid_q <= 1'b0;
      if ((state_q == REQ || state_q == RESP) && !cnt_last) cnt_q <= cnt_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          if (sba_req_i) begin
            addr_q  <= sba_addr_i;
            we_q    <= sba_we_i;
            wdata_q <= sba_wdata_i;
            be_q    <= sba_be_i;
            if (in_window) begin
              state_q   <= REQ;
              obi_req_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              state_q     <= RSP;
              after_rsp_q <= IDLE;
              rvalid_q    <= 1'b1;
              rdata_q     <= '0;
              err_q       <= 1'b1;
            end
          end
        end
        REQ: begin
          if (obi_gnt_i) begin
            obi_req_q <= 1'b0;
            state_q   <= RESP;
          end else if (cnt_last) begin
            // The request stays asserted: OBI does not allow it to be withdrawn.
            state_q     <= RSP;
            after_rsp_q <= DRAIN_GNT;
            rvalid_q    <= 1'b1;
            rdata_q     <= TimeoutData;
            err_q       <= 1'b1;
          end
        end
        RESP: begin
          if (obi_rvalid_i) begin
            state_q     <= RSP;
            after_rsp_q <= IDLE;
            rvalid_q    <= 1'b1;
            rdata_q     <= we_q ? '0 : obi_rdata_i;
            err_q       <= obi_err_i;
          end else if (cnt_last) begin
            state_q     <= RSP;
            after_rsp_q <= DRAIN_R;
            rvalid_q    <= 1'b1;
            rdata_q     <= TimeoutData;
            err_q       <= 1'b1;
          end
        end
        RSP: begin
          // A late grant or beat can land during the response cycle itself.
          if (after_rsp_q == DRAIN_GNT && obi_gnt_i) begin
            obi_req_q <= 1'b0;
            state_q   <= DRAIN_R;
          end else if (after_rsp_q == DRAIN_R && obi_rvalid_i) begin
            state_q <= IDLE;
          end else begin
            state_q <= after_rsp_q;
          end
        end
        DRAIN_GNT: begin
          if (obi_gnt_i) begin
            obi_req_q <= 1'b0;
            state_q   <= DRAIN_R;
          end
        end
        DRAIN_R: begin
          if (obi_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A response beat with nothing outstanding means the fabric is out of step with us.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(obi_rvalid_i && (state_q == IDLE || state_q == REQ)));

endmodule

// File: doc/rt_dbg_sba_obi_bridge.md
Name: rt_dbg_sba_obi_bridge

Overview:
- Adapts the debug module's system-bus-access (SBA) master port to the OBI crossbar.
- JTAG-driven memory reads and writes from the debug path become single outstanding OBI transactions.
- Adds an address-window check and a response timeout, so a hung or unmapped slave produces an SBA error instead of deadlocking the debug link.
- Sits between dm_top's master port and one OBI crossbar manager port.

Parameters:
- AddrWidth, 32, address width of both sides.
- DataWidth, 32, data width of both sides; BeWidth = DataWidth/8.
- WinStart, 32'h0001_0000, lowest accessible address (inclusive).
- WinEnd, 32'h0003_FFFF, highest accessible address (inclusive).
- TimeoutCycles, 1024, cycles allowed from OBI request issue to OBI response; must be >= 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- sba_req_i  in  1  SBA request
- sba_addr_i  in  AddrWidth  SBA address
- sba_we_i  in  1  SBA write enable
- sba_wdata_i  in  DataWidth  SBA write data
- sba_be_i  in  BeWidth  SBA byte enables
- sba_gnt_o  out  1  SBA request accepted
- sba_rvalid_o  out  1  SBA response valid, one-cycle pulse
- sba_rdata_o  out  DataWidth  SBA read data
- sba_err_o  out  1  SBA response error, qualified by sba_rvalid_o
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  AddrWidth  OBI address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  BeWidth  OBI byte enables
- obi_wdata_o  out  DataWidth  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  DataWidth  OBI read data
- obi_err_i  in  1  OBI response error
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset value of every output is 0. The FSM resets to IDLE and the timeout counter resets to 0.
- Reset mid-transaction abandons everything, including in-flight OBI transactions. The fabric must be reset together with this block.
- FSM states: IDLE, REQ, RESP, RSP, DRAIN_GNT, DRAIN_R.
- IDLE:
  - sba_gnt_o = sba_req_i, combinationally; at most one accept per IDLE visit.
  - On accept, latch addr/we/wdata/be.
  - Address in window (WinStart <= addr <= WinEnd) and addr[1:0] == 0: go to REQ.
  - Otherwise go to RSP with err = 1 and rdata = 0; no OBI traffic is generated.
- REQ:
  - obi_req_o = 1; obi_addr/we/be/wdata driven from the latches and held stable until grant.
  - The first obi_req_o is one cycle after sba_gnt_o.
  - On obi_gnt_i go to RESP; obi_req_o drops the next cycle.
- RESP:
  - On obi_rvalid_i, capture rdata (forced to 0 for writes) and err = obi_err_i, then go to RSP.
  - obi_rvalid_i is legal in the cycle after the grant at the earliest.
- RSP: sba_rvalid_o = 1 for exactly one cycle with the captured rdata/err, then go to IDLE.
- Latency: a zero-wait slave with gnt in the first REQ cycle and rvalid the next cycle gives sba_rvalid_o 3 cycles after sba_gnt_o.
- Timeout counter:
  - Clears on entry to REQ and increments each cycle in REQ and RESP.
  - Expires when count == TimeoutCycles-1 and no terminating event occurs that cycle.
  - On expiry, emit an error response (go to RSP with err = 1, rdata = 32'hDEAD_BEEF).
  - Expiry in REQ then goes to DRAIN_GNT; expiry in RESP then goes to DRAIN_R.
  - The counter saturates and does not wrap.
- Post-timeout drain:
  - After the RSP cycle, enter DRAIN_GNT or DRAIN_R instead of IDLE.
  - DRAIN_GNT keeps obi_req_o asserted with stable payload until grant (OBI forbids retracting a request), then goes to DRAIN_R.
  - DRAIN_R waits for obi_rvalid_i, discards it, and goes to IDLE.
  - sba_gnt_o = 0 in both drain states; no SBA response is produced for the discarded beat.
- Simultaneous events:
  - obi_rvalid_i in the expiry cycle: the real response wins and no timeout is flagged.
  - obi_gnt_i in the expiry cycle of REQ: the grant wins; go to RESP with the counter still running (saturated), so the next RESP cycle expires unless rvalid arrives.
- No SBA combinational path from obi_* inputs to sba_* outputs. All sba_rvalid_o/rdata/err values are registered.
- A stray obi_rvalid_i in IDLE/REQ is ignored and raises a simulation assertion.

Test Plan:
- Word write 0x0001_0040 <- 0xCAFE_F00D with be 4'hF, slave grants immediately -> obi_req_o one cycle after sba_gnt_o, payload matches, sba_rvalid_o 3 cycles after accept, err = 0, rdata = 0.
- Read 0x0001_0040 with slave gnt delayed 5 cycles and rvalid 3 cycles later returning 0xCAFE_F00D -> obi payload stable for all 5 REQ cycles, single sba_rvalid_o with rdata = 0xCAFE_F00D, err = 0.
- Read 0x0000_0100 (below window) and 0x0001_0002 (misaligned) -> sba_gnt_o then sba_rvalid_o with err = 1, rdata = 0, obi_req_o never asserted.
- TimeoutCycles = 16, slave grants but never responds -> err response with rdata 0xDEAD_BEEF 16 cycles after REQ entry; a new sba_req_i is not granted until a late rvalid arrives, which is discarded.
- TimeoutCycles = 16, gnt withheld for 40 cycles -> error response at cycle 16, obi_req_o stays high until gnt, then drain completes and the next transaction proceeds normally.
- rst_ni asserted mid-RESP -> all outputs 0 immediately, FSM in IDLE, and the next legal read completes normally.
